// File: rtl/data_register_arbiter.sv
// Round-robin arbiter sharing one single-port-write/comb-read register file
// between requesters A and B, with a full-array clear sequencer.
module data_register_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_req_valid,
    input  logic                  a_req_write,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_req_ready,
    output logic                  a_resp_valid,
    output logic [DATA_WIDTH-1:0] a_resp_data,
    input  logic                  b_req_valid,
    input  logic                  b_req_write,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_req_ready,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] b_resp_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  rf_enable_write,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic                    r_ptr_b;      // 1: B wins a tie, 0: A wins a tie
    logic                    r_a_resp_valid;
    logic [DATA_WIDTH-1:0]   r_a_resp_data;
    logic                    r_b_resp_valid;
    logic [DATA_WIDTH-1:0]   r_b_resp_data;
    logic                    r_clear_busy;
    logic                    w_grant_a;
    logic                    w_grant_b;
    logic                    w_clr_last;

    assign w_clr_last = (r_clr_cnt == '1);

    // Next state and grant selection
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_nxt = CLEAR;
                end else if (a_req_valid && b_req_valid) begin
                    w_grant_a = !r_ptr_b;
                    w_grant_b = r_ptr_b;
                end else begin
                    w_grant_a = a_req_valid;
                    w_grant_b = b_req_valid;
                end
            end
            CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end
    end

    // Register-file port steering
    always_comb begin
        rf_enable_write = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_read_addr    = '0;
        if (r_state == CLEAR && reset_n) begin
            rf_enable_write = 1'b1;
            rf_write_addr   = r_clr_cnt;
            rf_write_data   = CLEAR_VALUE;
        end else if (w_grant_a) begin
            if (a_req_write) begin
                rf_enable_write = 1'b1;
                rf_write_addr   = a_req_addr;
                rf_write_data   = a_req_wdata;
            end else begin
                rf_read_addr    = a_req_addr;
            end
        end else if (w_grant_b) begin
            if (b_req_write) begin
                rf_enable_write = 1'b1;
                rf_write_addr   = b_req_addr;
                rf_write_data   = b_req_wdata;
            end else begin
                rf_read_addr    = b_req_addr;
            end
        end
    end

    assign a_req_ready  = w_grant_a;
    assign b_req_ready  = w_grant_b;
    assign a_resp_valid = r_a_resp_valid;
    assign a_resp_data  = r_a_resp_data;
    assign b_resp_valid = r_b_resp_valid;
    assign b_resp_data  = r_b_resp_data;
    assign clear_busy   = r_clear_busy;

    // State, counter, pointer and response registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_clr_cnt      <= '0;
            r_ptr_b        <= 1'b0;
            r_a_resp_valid <= 1'b0;
            r_a_resp_data  <= '0;
            r_b_resp_valid <= 1'b0;
            r_b_resp_data  <= '0;
            r_clear_busy   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_busy <= (w_state_nxt == CLEAR);
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
            end
            if (w_grant_a) begin
                r_ptr_b <= 1'b1;
            end else if (w_grant_b) begin
                r_ptr_b <= 1'b0;
            end
            r_a_resp_valid <= w_grant_a && !a_req_write;
            r_b_resp_valid <= w_grant_b && !b_req_write;
            if (w_grant_a && !a_req_write) begin
                r_a_resp_data <= rf_read_data;
            end
            if (w_grant_b && !b_req_write) begin
                r_b_resp_data <= rf_read_data;
            end
        end
    end

endmodule
